// File: rtl/mux_channel_scanner.sv
// mux_channel_scanner: walks enabled mux channels, samples each after a settle time, emits a parallel word
module mux_channel_scanner #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   chan_mask,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   word,
  output logic             valid,
  output logic             busy
);
  localparam int CW = $clog2(DWELL + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t          state, state_nx;
  logic [NCH-1:0]  mask, src;
  logic [CW-1:0]   cnt;
  logic [SEL_W-1:0] first, next_up;
  logic            has_next;
  // channel search: lowest enabled channel, and the next enabled one above sel
  always_comb begin
    src      = (state == IDLE) ? chan_mask : mask;
    first    = '0;
    next_up  = '0;
    has_next = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (src[i]) first = SEL_W'(i);
      if (src[i] && SEL_W'(i) > sel) begin
        next_up  = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end
  // next-state decision
  always_comb begin
    state_nx = (state == IDLE)   ? (start ? ((|chan_mask) ? SETTLE : DONE) : IDLE) :
               (state == SETTLE) ? ((cnt == CW'(DWELL - 1)) ? SAMPLE : SETTLE) :
               (state == SAMPLE) ? (has_next ? SETTLE : DONE) :
                                   ((cont && (|mask)) ? SETTLE : IDLE);
  end
  // state register plus select, dwell counter, latched mask and result word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      word  <= '0;
      mask  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          mask <= chan_mask;
          word <= '0;
          cnt  <= '0;
          if (|chan_mask) sel <= first;
        end
        SETTLE: cnt <= cnt + CW'(1);
        SAMPLE: begin
          word[sel] <= mux_out;
          cnt       <= '0;
          if (has_next) sel <= next_up;
        end
        DONE: begin
          cnt <= '0;
          if (cont && (|mask)) sel <= first;
        end
      endcase
    end
  end
  // status outputs decoded from the state
  always_comb begin
    valid = (state == DONE);
    busy  = (state != IDLE);
  end
endmodule

// File: tb/tb_mux_channel_scanner.sv
// tb_mux_channel_scanner: directed and random scans checked against a channel-list model
module tb_mux_channel_scanner;
  localparam int NCH = 4, SEL_W = 2, DWELL = 2;
  logic clk = 0, rst_n = 0, start = 0, cont = 0;
  logic [NCH-1:0] chan_mask = '0, pat = '0, word, exp_word = '0;
  logic [SEL_W-1:0] sel;
  logic mux_out, valid, busy;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign mux_out = pat[sel];
  mux_channel_scanner #(.NCH(NCH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .chan_mask(chan_mask),
    .mux_out(mux_out), .sel(sel), .word(word), .valid(valid), .busy(busy)
  );
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one pass over the enabled channels, entered at the negedge of the first settle cycle
  task automatic scan_body(input logic [NCH-1:0] m, input logic [NCH-1:0] p, input bit junk);
    int q[$];
    for (int i = 0; i < NCH; i++) if (m[i]) q.push_back(i);
    foreach (q[j]) begin
      for (int d = 0; d <= DWELL; d++) begin
        chk("sel", sel, q[j]);
        chk("valid_low", valid, 0);
        chk("busy_scan", busy, 1);
        chk("word_scan", word, exp_word);
        start = (junk && !(j == q.size() - 1 && d == DWELL)) ? 1'($urandom) : 1'b0;
        if (junk) chan_mask = NCH'($urandom);
        @(negedge clk);
      end
      exp_word[q[j]] = p[q[j]];
    end
    chk("valid_done", valid, 1);
    chk("word_done", word, exp_word);
    chk("busy_done", busy, 1);
  endtask
  task automatic fresh_scan(input logic [NCH-1:0] m, input logic [NCH-1:0] p, input bit junk);
    start = 1;
    chan_mask = m;
    pat = p;
    @(negedge clk);
    start = 0;
    exp_word = '0;
    if (m == '0) begin
      chk("valid_zero", valid, 1);
      chk("word_zero", word, 0);
      chk("busy_zero", busy, 1);
    end else scan_body(m, p, junk);
    if (!cont || m == '0) begin
      @(negedge clk);
      chk("valid_after", valid, 0);
      chk("busy_after", busy, 0);
      chk("word_hold", word, exp_word);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_word", word, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);
    fresh_scan(4'b1111, 4'b1101, 0);
    fresh_scan(4'b1010, 4'b1010, 0);
    fresh_scan(4'b0000, 4'b1111, 0);
    fresh_scan(4'b0110, 4'b0100, 1);
    fresh_scan(4'b1001, 4'b1111, 1);
    start = 1;
    chan_mask = 4'b1111;
    pat = 4'b1111;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_sel", sel, 0);
    chk("midrst_word", word, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    fresh_scan(4'b1111, 4'b0101, 0);
    cont = 1;
    fresh_scan(4'b0001, 4'b0001, 0);
    for (int r = 0; r < 4; r++) begin
      pat = NCH'(r % 2);
      @(negedge clk);
      scan_body(4'b0001, pat, 0);
    end
    cont = 0;
    @(negedge clk);
    chk("cont_off_valid", valid, 0);
    chk("cont_off_busy", busy, 0);
    chk("cont_off_word", word, exp_word);
    repeat (25) fresh_scan(NCH'($urandom), NCH'($urandom), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
